// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Includes the state encoding, the stream framing constants and the default memory depth.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_DEPTH     = 100;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// It owns the byte lane index; last_lane flags that the next accepted byte completes the word.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        lane_valid,
    input  logic        clear,
    output logic [31:0] word,
    output logic        last_lane
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] byte_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (lane_valid) begin
            word[byte_idx*8 +: 8] <= data;
            byte_idx              <= byte_idx + 1'b1;
        end
    end

    assign last_lane = (byte_idx == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: reads a counted byte stream and writes instruction words while holding the core in reset.
// The core's reset is released only after a load completes successfully.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int WIDX_W = $clog2(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_full;
    logic [WIDX_W-1:0] widx;
    logic              xfer;
    logic              take_start;
    logic              last_lane;
    logic [31:0]       packed_word;

    // in_ready depends on the state register only, so there is no input-to-output path.
    always_comb begin
        in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
    end

    assign xfer       = in_valid && in_ready;
    assign take_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign count_full = {in_data, count[7:0]};
    assign mem_wdata  = packed_word;

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .data       (in_data),
        .lane_valid (xfer && (state == DATA)),
        .clear      (take_start),
        .word       (packed_word),
        .last_lane  (last_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            widx      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN0;
                        widx      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
                        state      <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        count <= count_full;
                        if (count_full == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else if (count_full > CNT_W'(DEPTH)) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer && last_lane) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        mem_addr <= {{(32-WIDX_W-2){1'b0}}, widx, 2'b00};
                    end
                end
                WRITE: begin
                    widx <= widx + 1'b1;
                    if (CNT_W'(widx) == count - CNT_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte and returns on the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fails++;
            $display("FAIL send_byte_timeout: in_ready=%b expected 1 within 50 cycles", in_ready);
        end
        tests++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        tests++;
        if (mem_we !== 1'b0)    begin fails++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        tests++;
        if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        tests++;
        if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        tests++;
        if (cpu_rst_n !== 1'b0) begin fails++; $display("FAIL rst_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        tests++;
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tests++;
        if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
        tests++;
        if (err !== 1'b0)       begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
        tests++;
    endtask

    task automatic run_two_word(input int gap, input string tag);
        logic [7:0] b [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        wa_q.delete();
        wd_q.delete();
        do_start();
        if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL %s_after_start: ready/busy/cpu_rst_n got %b%b%b expected 110", tag, in_ready, busy, cpu_rst_n);
        end
        tests++;
        for (int i = 0; i < 10; i++) begin
            send_byte(b[i]);
            if (i == 5) begin
                if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00500513) begin
                    fails++;
                    $display("FAIL %s_write0: we=%b addr=%h data=%h expected we=1 addr=0 data=00500513", tag, mem_we, mem_addr, mem_wdata);
                end
                tests++;
            end
            if (i != 9) repeat (gap) @(negedge clk);
        end
        if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h00A00593 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_write1: we=%b addr=%h data=%h done=%b expected we=1 addr=4 data=00a00593 done=0", tag, mem_we, mem_addr, mem_wdata, done);
        end
        tests++;
        @(negedge clk);
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: done/cpu_rst_n/busy/we got %b%b%b%b expected 1100", tag, done, cpu_rst_n, busy, mem_we);
        end
        tests++;
        if (wa_q.size() != 2) begin
            fails++;
            $display("FAIL %s_write_count: got %0d expected 2", tag, wa_q.size());
        end else if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500513 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00A00593) begin
            fails++;
            $display("FAIL %s_write_log: got %h:%h %h:%h expected 0:00500513 4:00a00593", tag, wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
        tests++;
    endtask

    task automatic test_normal();
        run_two_word(0, "normal");
    endtask

    task automatic test_bubbles();
        run_two_word(3, "bubbles");
    endtask

    task automatic test_empty();
        wa_q.delete();
        wd_q.delete();
        do_start();
        if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL empty_restart: cpu_rst_n=%b done=%b expected 0 0", cpu_rst_n, done);
        end
        tests++;
        send_byte(8'h00);
        send_byte(8'h00);
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_done: done/cpu_rst_n/busy/ready got %b%b%b%b expected 1100", done, cpu_rst_n, busy, in_ready);
        end
        tests++;
        @(negedge clk);
        if (wa_q.size() != 0) begin
            fails++;
            $display("FAIL empty_no_write: got %0d writes expected 0", wa_q.size());
        end
        tests++;
    endtask

    task automatic test_oversize();
        wa_q.delete();
        wd_q.delete();
        do_start();
        send_byte(8'h65);
        send_byte(8'h00);
        if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL oversize_err: err/done/cpu_rst_n/ready/busy got %b%b%b%b%b expected 10000", err, done, cpu_rst_n, in_ready, busy);
        end
        tests++;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        if (wa_q.size() != 0 || in_ready !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL oversize_hold: writes=%0d ready=%b err=%b expected 0 0 1", wa_q.size(), in_ready, err);
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        wa_q.delete();
        wd_q.delete();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        rst = 1'b1;
        #1;
        if (busy !== 1'b0 || in_ready !== 1'b0 || mem_wdata !== 32'h0 || mem_addr !== 32'h0 ||
            mem_we !== 1'b0 || cpu_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: busy=%b ready=%b wdata=%h addr=%h we=%b cpu_rst_n=%b done=%b err=%b expected all 0",
                     busy, in_ready, mem_wdata, mem_addr, mem_we, cpu_rst_n, done, err);
        end
        tests++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL midrst_write: we=%b addr=%h data=%h expected 1 0 deadbeef", mem_we, mem_addr, mem_wdata);
        end
        tests++;
        @(negedge clk);
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || wa_q.size() != 1) begin
            fails++;
            $display("FAIL midrst_done: done=%b cpu_rst_n=%b writes=%0d expected 1 1 1", done, cpu_rst_n, wa_q.size());
        end
        tests++;
    endtask

    task automatic test_start_handling();
        wa_q.delete();
        wd_q.delete();
        do_start();
        if (cpu_rst_n !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_from_done: cpu_rst_n=%b done=%b ready=%b expected 0 0 1", cpu_rst_n, done, in_ready);
        end
        tests++;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        do_start();
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_in_data: busy=%b ready=%b expected 1 1", busy, in_ready);
        end
        tests++;
        send_byte(8'h34);
        send_byte(8'h12);
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h12345678) begin
            fails++;
            $display("FAIL start_write: we=%b addr=%h data=%h expected 1 0 12345678", mem_we, mem_addr, mem_wdata);
        end
        tests++;
        @(negedge clk);
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || wa_q.size() != 1) begin
            fails++;
            $display("FAIL start_done: done=%b cpu_rst_n=%b writes=%0d expected 1 1 1", done, cpu_rst_n, wa_q.size());
        end
        tests++;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_normal();
        test_empty();
        test_oversize();
        test_bubbles();
        test_reset_mid();
        test_start_handling();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RV32I core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into instruction memory while holding the core in reset, then releases the core. It is the write side of the instruction-memory interface that the core only ever reads.

## Interface
- DEPTH, 100: instruction-memory size in words; the maximum legal word count.
- CNT_W, 16: width of the word-count header.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the word being written (word index × 4, the PC value the core fetches).
- mem_wdata  output  32  assembled instruction word.
- cpu_rst_n  output  1  active-low reset to the core; low from reset until a load completes.
- busy  output  1  load in progress (states LEN0, LEN1, DATA, WRITE).
- done  output  1  last load completed successfully.
- err  output  1  last load was rejected because the header count exceeds DEPTH.

## Operation
- Stream format: 2 header bytes giving the word count N (LSB first), then N×4 data bytes, each word LSB first.
- A byte transfers on a rising clk edge when in_valid && in_ready. in_ready is a Moore output of the state. Upstream holds in_data stable while in_valid is high and in_ready is low.
- The FSM has seven states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
- **IDLE:** in_ready=0. On start, go to LEN0 and clear the word index and byte index.
- **LEN0:** in_ready=1. On a transfer, count[7:0] ← in_data, then go to LEN1.
- **LEN1:** in_ready=1. On a transfer, count[15:8] ← in_data. Then:
  - if N==0, go to DONE;
  - else if N>DEPTH, go to ERR;
  - else go to DATA.
- **DATA:** in_ready=1. Each transfer writes in_data into word byte lane byte_idx, then byte_idx increments. On the transfer with byte_idx==3, go to WRITE and wrap byte_idx to 0.
- **WRITE:** in_ready=0 and mem_we=1 for exactly one cycle, with mem_addr = widx<<2 and mem_wdata = the assembled word. widx increments. If widx == N−1, go to DONE; otherwise go to DATA.
- **DONE:** done=1, cpu_rst_n=1, in_ready=0. On start, go to LEN0, drop cpu_rst_n to 0, and clear done.
- **ERR:** err=1, cpu_rst_n=0, in_ready=0. No memory writes occur in ERR. On start, go to LEN0 and clear err.
- Ignored inputs:
  - start in LEN0, LEN1, DATA or WRITE.
  - in_valid in IDLE, WRITE, DONE and ERR; no bytes are consumed in those states.
- Previously written words beyond a new, shorter N are left untouched.

## Timing
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_rst_n=0, busy=0, done=0, err=0;
  - count=0, widx=0, byte_idx=0.
- All outputs except in_ready are registered. in_ready is decoded from the state register only, with no input-to-output combinational path.
- mem_we is high in the cycle after the 4th byte handshake of a word.
- With in_valid held high, throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- done/cpu_rst_n rise in the cycle after the last WRITE cycle, or after the LEN1 handshake when N==0.
- err rises in the cycle after the LEN1 handshake.
- start in DONE/ERR: cpu_rst_n=0 (from DONE) and in_ready=1 in the following cycle.
- rst mid-load (any state) returns all outputs to their reset values immediately. The partial word is discarded, and the next start re-expects a header.
- widx width is clog2(DEPTH). The N>DEPTH check uses the full 16-bit count, so no wrap-around is possible.

## Structure
- The shared package holds:
  - the loader state enum;
  - LEN_BYTES=2 and BYTES_PER_WORD=4;
  - the default DEPTH=100, the same constant used by instruction memory.
- One sub-module, word_packer:
  - inputs: byte, lane valid, clear;
  - outputs: the 32-bit word and a last-lane flag;
  - owns byte_idx and lane placement.
- The top-level FSM owns count, widx, the handshake and the outputs.

## Test plan
- **Normal 2-word load:** start, then bytes 02 00 13 05 50 00 93 05 A0 00 → mem_we at 0x0 with 0x00500513, then at 0x4 with 0x00A00593; done=1 and cpu_rst_n=1 one cycle after the second write.
- **Empty load:** start, then bytes 00 00 → no mem_we; done=1 and cpu_rst_n=1 one cycle after the second header byte.
- **Oversize header:** start, then bytes 65 00 (N=101, DEPTH=100) → err=1, done=0, cpu_rst_n=0, in_ready=0, and no mem_we even if more bytes are offered.
- **Bubbles:** repeat the normal 2-word load with in_valid low for 3 cycles between every byte → identical writes and values; no byte is consumed while in_ready=0 during WRITE.
- **Reset mid-load:** assert rst after 2 data bytes of word 0 → all outputs return to reset values. Then start, then bytes 01 00 EF BE AD DE → one write at 0x0 with 0xDEADBEEF.
- **Start handling:** start pulses during DATA are ignored (data unchanged). After done, start plus 01 00 78 56 34 12 → cpu_rst_n=0 the next cycle, a write at 0x0 with 0x12345678, then done=1 again.
